// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave
//   AHB-Lite SRAM slave with programmable wait states, byte-lane writes and
//   the two-cycle ERROR response for out-of-range, misaligned or oversized
//   transfers. Array contents are not reset.
//
// Ports
//   HCLK       in   clock, rising edge
//   HRESET     in   synchronous active-high reset
//   HSEL       in   slave select
//   HADDR      in   byte address (WIDTH)
//   HTRANS     in   0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
//   HWRITE     in   1 = write
//   HSIZE      in   log2 transfer bytes
//   HBURST     in   unused
//   HPROT      in   unused
//   HMASTLOCK  in   unused
//   HWDATA     in   write data, data phase (WIDTH)
//   HREADY     in   bus ready, qualifies address sampling
//   HREADYOUT  out  slave ready
//   HRESP      out  0 OKAY, 1 ERROR
//   HRDATA     out  read data, zero outside a read data phase (WIDTH)
module ahb_sram_slave #(
  parameter int              WIDTH       = 32,
  parameter int              DEPTH       = 256,
  parameter int              WAIT_STATES = 0,
  parameter logic [WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             HSEL,
  input  logic [WIDTH-1:0] HADDR,
  input  logic [1:0]       HTRANS,
  input  logic             HWRITE,
  input  logic [2:0]       HSIZE,
  input  logic [2:0]       HBURST,
  input  logic [3:0]       HPROT,
  input  logic             HMASTLOCK,
  input  logic [WIDTH-1:0] HWDATA,
  input  logic             HREADY,
  output logic             HREADYOUT,
  output logic             HRESP,
  output logic [WIDTH-1:0] HRDATA
);

  localparam int NB    = WIDTH / 8;
  localparam int OB    = $clog2(NB);
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BYTES = DEPTH * NB;

  typedef enum logic [1:0] {S_READY, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t           r_state;
  logic [2:0]       r_cnt;
  logic             r_pend;   // non-erroring data phase in progress
  logic [WIDTH-1:0] r_off;
  logic             r_write;
  logic [2:0]       r_size;
  logic             r_hready;
  logic             r_hresp;

  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [WIDTH-1:0] w_off;
  logic [WIDTH-1:0] w_amask;
  logic             w_acc;
  logic             w_err;
  logic [IW-1:0]    w_idx;
  logic [OB-1:0]    w_boff;
  logic [NB-1:0]    w_be;
  logic             w_commit;
  logic             w_unused;

  // Only READY and ERR2 drive HREADYOUT high, so only they can see an
  // address phase; gating here keeps a misbehaving HREADY harmless.
  assign w_acc   = HSEL & HREADY & HTRANS[1] &
                   ((r_state == S_READY) | (r_state == S_ERR2));
  // Wrapping subtraction: addresses below BASE_ADDR land far out of range.
  assign w_off   = HADDR - BASE_ADDR;
  assign w_amask = ~({WIDTH{1'b1}} << HSIZE);
  assign w_err   = (w_off >= WIDTH'(BYTES)) | (HSIZE > 3'(OB)) |
                   (|(HADDR & w_amask));

  assign w_idx    = r_off[OB +: IW];
  assign w_boff   = r_off[OB-1:0];
  // A pending transfer in READY is in its last data-phase cycle.
  assign w_commit = r_pend & r_write & (r_state == S_READY) & ~HRESET;

  always_comb begin
    w_be = '0;
    for (int b = 0; b < NB; b++)
      w_be[b] = (b >= int'(w_boff)) && (b < int'(w_boff) + (32'sd1 << r_size));
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state  <= S_READY;
      r_cnt    <= '0;
      r_pend   <= 1'b0;
      r_off    <= '0;
      r_write  <= 1'b0;
      r_size   <= '0;
      r_hready <= 1'b1;
      r_hresp  <= 1'b0;
    end else begin
      if (w_acc) begin
        r_off   <= w_off;
        r_write <= HWRITE;
        r_size  <= HSIZE;
      end
      case (r_state)
        S_READY, S_ERR2: begin
          if (w_acc && w_err) begin
            r_state  <= S_ERR1;
            r_pend   <= 1'b0;
            r_hready <= 1'b0;
            r_hresp  <= 1'b1;
          end else if (w_acc && (WAIT_STATES > 0)) begin
            r_state  <= S_WAIT;
            r_cnt    <= 3'(WAIT_STATES - 1);
            r_pend   <= 1'b1;
            r_hready <= 1'b0;
            r_hresp  <= 1'b0;
          end else begin
            r_state  <= S_READY;
            r_pend   <= w_acc;
            r_hready <= 1'b1;
            r_hresp  <= 1'b0;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_state  <= S_READY;
            r_hready <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        S_ERR1: begin
          r_state  <= S_ERR2;
          r_hready <= 1'b1;
          r_hresp  <= 1'b1;
        end
        default: begin
          r_state  <= S_READY;
          r_pend   <= 1'b0;
          r_hready <= 1'b1;
          r_hresp  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (w_commit)
      for (int b = 0; b < NB; b++)
        if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= HWDATA[b*8 +: 8];
  end

  assign HREADYOUT = r_hready;
  assign HRESP     = r_hresp;
  // Combinational read of the registered index: a read accepted on the same
  // edge that commits a write to that word sees the new data.
  assign HRDATA    = (r_pend && !r_write) ? r_mem[w_idx] : '0;

  assign w_unused = ^{HBURST, HPROT, HMASTLOCK, r_off};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed-vector bench: three slave instances (0, 2 and 3 wait states)
// share one bus; each vector selects one instance and carries the outputs
// expected in the cycle after its edge. The driver pushes expectations into
// a scoreboard queue; a separate monitor pops and compares every cycle.
module tb_ahb_sram_slave;

  logic        HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  logic        HRESET = 1'b1;
  logic [2:0]  sel    = '0;
  logic [31:0] HADDR  = '0;
  logic [31:0] HWDATA = '0;
  logic [1:0]  HTRANS = '0;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE  = '0;
  logic        ro [3];
  logic        rp [3];
  logic [31:0] rd [3];

  ahb_sram_slave #(.WIDTH(32), .DEPTH(256), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_ws0 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(sel[0]), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(3'd0), .HPROT(4'd0), .HMASTLOCK(1'b0),
    .HWDATA(HWDATA), .HREADY(ro[0]), .HREADYOUT(ro[0]), .HRESP(rp[0]), .HRDATA(rd[0]));

  ahb_sram_slave #(.WIDTH(32), .DEPTH(256), .WAIT_STATES(2), .BASE_ADDR(32'h0)) u_ws2 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(sel[1]), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(3'd0), .HPROT(4'd0), .HMASTLOCK(1'b0),
    .HWDATA(HWDATA), .HREADY(ro[1]), .HREADYOUT(ro[1]), .HRESP(rp[1]), .HRDATA(rd[1]));

  ahb_sram_slave #(.WIDTH(32), .DEPTH(256), .WAIT_STATES(3), .BASE_ADDR(32'h0)) u_ws3 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(sel[2]), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(3'd0), .HPROT(4'd0), .HMASTLOCK(1'b0),
    .HWDATA(HWDATA), .HREADY(ro[2]), .HREADYOUT(ro[2]), .HRESP(rp[2]), .HRDATA(rd[2]));

  localparam logic [1:0] IDL = 2'd0, BSY = 2'd1, NS = 2'd2, SQ = 2'd3;

  typedef struct {
    bit          rst;
    int          dut;
    bit          sel;
    logic [1:0]  tr;
    bit          wr;
    logic [2:0]  sz;
    logic [31:0] addr;
    logic [31:0] wd;
    bit          erdy;
    bit          eresp;
    logic [31:0] erd;
  } vec_t;

  typedef struct {
    int          id;
    int          dut;
    bit          rdy;
    bit          resp;
    logic [31:0] rd;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   napplied   = 0;
  int   miscompares = 0;

  function automatic void add(bit rst, int dut, bit s, logic [1:0] tr, bit wr,
                              logic [2:0] sz, logic [31:0] a, logic [31:0] wd,
                              bit r, bit e, logic [31:0] d);
    vec_t v;
    v = '{rst, dut, s, tr, wr, sz, a, wd, r, e, d};
    vecs.push_back(v);
  endfunction

  // Driver: apply one vector per cycle at the falling edge.
  initial begin
    //  rst dut sel tr   wr sz  addr          wdata         rdy resp rdata
    add(1,  0,  0,  IDL, 0, 2, 32'h0,        32'h0,        1, 0, 32'h0);
    add(1,  0,  0,  IDL, 0, 2, 32'h0,        32'h0,        1, 0, 32'h0);
    // zero-wait write then back-to-back read of the same word
    add(0,  0,  1,  NS,  1, 2, 32'h10,       32'h0,        1, 0, 32'h0);
    add(0,  0,  1,  NS,  0, 2, 32'h10,       32'hDEADBEEF, 1, 0, 32'hDEADBEEF);
    // preload words 0x4 and 0x0, byte write to 0x6, read 0x4
    add(0,  0,  1,  NS,  1, 2, 32'h4,        32'h0,        1, 0, 32'h0);
    add(0,  0,  1,  NS,  1, 2, 32'h0,        32'h11223344, 1, 0, 32'h0);
    add(0,  0,  1,  NS,  1, 0, 32'h6,        32'hA5A5A5A5, 1, 0, 32'h0);
    add(0,  0,  1,  NS,  0, 2, 32'h4,        32'h00AB0000, 1, 0, 32'h11AB3344);
    // out of range, then misaligned halfword accepted straight out of ERR2
    add(0,  0,  1,  NS,  1, 2, 32'h400,      32'h0,        0, 1, 32'h0);
    add(0,  0,  1,  IDL, 0, 2, 32'h0,        32'hFFFFFFFF, 1, 1, 32'h0);
    add(0,  0,  1,  NS,  1, 1, 32'h3,        32'hFFFFFFFF, 0, 1, 32'h0);
    add(0,  0,  1,  IDL, 0, 2, 32'h0,        32'hFFFFFFFF, 1, 1, 32'h0);
    add(0,  0,  1,  NS,  0, 2, 32'h0,        32'hFFFFFFFF, 1, 0, 32'hA5A5A5A5);
    add(0,  0,  1,  SQ,  0, 2, 32'h4,        32'h0,        1, 0, 32'h11AB3344);
    // BUSY, IDLE and deselected NONSEQ are never accepted
    add(0,  0,  1,  BSY, 0, 2, 32'h10,       32'h0,        1, 0, 32'h0);
    add(0,  0,  1,  IDL, 1, 2, 32'h10,       32'h0,        1, 0, 32'h0);
    add(0,  0,  0,  NS,  1, 2, 32'h10,       32'h0,        1, 0, 32'h0);
    add(0,  0,  1,  IDL, 0, 2, 32'h0,        32'h0,        1, 0, 32'h0);
    add(0,  0,  1,  NS,  0, 2, 32'h10,       32'h0,        1, 0, 32'hDEADBEEF);
    // oversized (doubleword on a 32-bit slave)
    add(0,  0,  1,  NS,  0, 3, 32'h8,        32'h0,        0, 1, 32'h0);
    add(0,  0,  1,  IDL, 0, 2, 32'h0,        32'h0,        1, 1, 32'h0);
    add(0,  0,  1,  IDL, 0, 2, 32'h0,        32'h0,        1, 0, 32'h0);
    // last word in range
    add(0,  0,  1,  NS,  1, 2, 32'h3FC,      32'h0,        1, 0, 32'h0);
    add(0,  0,  1,  NS,  0, 2, 32'h3FC,      32'h13572468, 1, 0, 32'h13572468);
    add(0,  0,  1,  IDL, 0, 2, 32'h0,        32'h0,        1, 0, 32'h0);
    // two wait states: write 0x10, read it back, then an error without waits
    add(0,  1,  1,  NS,  1, 2, 32'h10,       32'h0,        0, 0, 32'h0);
    add(0,  1,  1,  IDL, 0, 2, 32'h0,        32'hCAFEF00D, 0, 0, 32'h0);
    add(0,  1,  1,  IDL, 0, 2, 32'h0,        32'hCAFEF00D, 1, 0, 32'h0);
    add(0,  1,  1,  NS,  0, 2, 32'h10,       32'hCAFEF00D, 0, 0, 32'hCAFEF00D);
    add(0,  1,  1,  IDL, 0, 2, 32'h0,        32'h0,        0, 0, 32'hCAFEF00D);
    add(0,  1,  1,  IDL, 0, 2, 32'h0,        32'h0,        1, 0, 32'hCAFEF00D);
    add(0,  1,  1,  IDL, 0, 2, 32'h0,        32'h0,        1, 0, 32'h0);
    add(0,  1,  1,  NS,  1, 2, 32'h400,      32'h0,        0, 1, 32'h0);
    add(0,  1,  1,  IDL, 0, 2, 32'h0,        32'h0,        1, 1, 32'h0);
    add(0,  1,  1,  IDL, 0, 2, 32'h0,        32'h0,        1, 0, 32'h0);
    // three wait states: preload 0x8, rewrite it and reset in 2nd wait cycle
    add(0,  2,  1,  NS,  1, 2, 32'h8,        32'h0,        0, 0, 32'h0);
    add(0,  2,  1,  IDL, 0, 2, 32'h0,        32'h12345678, 0, 0, 32'h0);
    add(0,  2,  1,  IDL, 0, 2, 32'h0,        32'h12345678, 0, 0, 32'h0);
    add(0,  2,  1,  IDL, 0, 2, 32'h0,        32'h12345678, 1, 0, 32'h0);
    add(0,  2,  1,  NS,  1, 2, 32'h8,        32'h12345678, 0, 0, 32'h0);
    add(0,  2,  1,  IDL, 0, 2, 32'h0,        32'hBAD0BAD0, 0, 0, 32'h0);
    add(1,  2,  1,  IDL, 0, 2, 32'h0,        32'hBAD0BAD0, 1, 0, 32'h0);
    add(0,  2,  1,  NS,  0, 2, 32'h8,        32'hBAD0BAD0, 0, 0, 32'h12345678);
    add(0,  2,  1,  IDL, 0, 2, 32'h0,        32'hBAD0BAD0, 0, 0, 32'h12345678);
    add(0,  2,  1,  IDL, 0, 2, 32'h0,        32'hBAD0BAD0, 0, 0, 32'h12345678);
    add(0,  2,  1,  IDL, 0, 2, 32'h0,        32'hBAD0BAD0, 1, 0, 32'h12345678);
    add(0,  2,  1,  IDL, 0, 2, 32'h0,        32'h0,        1, 0, 32'h0);

    foreach (vecs[i]) begin
      exp_t e;
      @(negedge HCLK);
      HRESET = vecs[i].rst;
      sel    = vecs[i].sel ? 3'(1 << vecs[i].dut) : 3'b000;
      HTRANS = vecs[i].tr;
      HWRITE = vecs[i].wr;
      HSIZE  = vecs[i].sz;
      HADDR  = vecs[i].addr;
      HWDATA = vecs[i].wd;
      e = '{i, vecs[i].dut, vecs[i].erdy, vecs[i].eresp, vecs[i].erd};
      sb.push_back(e);
    end

    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge HCLK);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", napplied, miscompares);
    $finish;
  end

  // Monitor: outputs are registered, so sample shortly after the rising edge.
  initial begin
    forever begin
      exp_t e;
      @(posedge HCLK);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        napplied++;
        if (ro[e.dut] !== e.rdy) begin
          miscompares++;
          $display("FAIL v%0d dut%0d hreadyout: got %b, required %b", e.id, e.dut, ro[e.dut], e.rdy);
        end
        if (rp[e.dut] !== e.resp) begin
          miscompares++;
          $display("FAIL v%0d dut%0d hresp: got %b, required %b", e.id, e.dut, rp[e.dut], e.resp);
        end
        if (rd[e.dut] !== e.rd) begin
          miscompares++;
          $display("FAIL v%0d dut%0d hrdata: got %h, required %h", e.id, e.dut, rd[e.dut], e.rd);
        end
      end
    end
  end

endmodule
